// File: rtl/tx_ser_if.sv
// Byte-request and serial-line signals between a transmit client and tx_ser.
// The master drives the byte request; the slave (tx_ser) drives the line and status.
interface tx_ser_if;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       ready;
    logic       tx_out;
    logic       start;
    logic       busy;

    modport master (
        output p_data, data_valid, par_en, par_typ,
        input  ready, tx_out, start, busy
    );

    modport slave (
        input  p_data, data_valid, par_en, par_typ,
        output ready, tx_out, start, busy
    );
endinterface

// File: rtl/tx_ser.sv
// Serialiser: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit.
// A one-entry holding register allows back-to-back frames with no idle gap.
module tx_ser (
    input  logic    clk,
    input  logic    rst,
    tx_ser_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shf_q, shf_d;
    logic       par_en_q, par_en_d;
    logic       par_bit_q, par_bit_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_pe_q, hold_pe_d;
    logic       hold_pt_q, hold_pt_d;
    logic       hold_full_q, hold_full_d;
    logic       tx_q, tx_d;
    logic       start_q, start_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;
    logic       accept;
    logic       load;

    // ready_q is only high while the holding register is empty, so accept and load never coincide.
    assign accept = bus.data_valid & ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            shf_q       <= 8'd0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            hold_data_q <= 8'd0;
            hold_pe_q   <= 1'b0;
            hold_pt_q   <= 1'b0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shf_q       <= shf_d;
            par_en_q    <= par_en_d;
            par_bit_q   <= par_bit_d;
            hold_data_q <= hold_data_d;
            hold_pe_q   <= hold_pe_d;
            hold_pt_q   <= hold_pt_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shf_d       = shf_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        hold_data_d = hold_data_q;
        hold_pe_d   = hold_pe_q;
        hold_pt_d   = hold_pt_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;
        case (state_q)
            StIdle:   load = hold_full_q;
            StStart: begin
                state_d = StData;
                cnt_d   = 3'd0;
            end
            StData: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = par_en_q ? StParity : StStop;
                end
            end
            StParity: state_d = StStop;
            StStop: begin
                load    = hold_full_q;
                state_d = StIdle;
            end
            default:  state_d = StIdle;
        endcase
        // Parity is resolved at load time so the in-flight frame depends only on latched values.
        if (load) begin
            state_d     = StStart;
            shf_d       = hold_data_q;
            par_en_d    = hold_pe_q;
            par_bit_d   = (^hold_data_q) ^ hold_pt_q;
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = bus.p_data;
            hold_pe_d   = bus.par_en;
            hold_pt_d   = bus.par_typ;
        end
    end

    // Outputs are computed from next state so the registered line bit aligns with the state.
    always_comb begin
        tx_d    = 1'b1;
        start_d = 1'b1;
        case (state_d)
            StIdle:   start_d = 1'b0;
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shf_d[cnt_d];
            StParity: tx_d = par_bit_d;
            StStop:   tx_d = 1'b1;
            default:  start_d = 1'b0;
        endcase
        busy_d  = (state_d != StIdle) | hold_full_d;
        ready_d = ~hold_full_d;
    end

    assign bus.tx_out = tx_q;
    assign bus.start  = start_q;
    assign bus.busy   = busy_q;
    assign bus.ready  = ready_q;
endmodule

// File: tb/tb_tx_ser.sv
// Bench for tx_ser: a frame-level model (queue of line bits plus one held byte) is compared
// every cycle, and directed frames are pinned against hand-written bit sequences.
module tb_tx_ser;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    tx_ser_if bus ();

    tx_ser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    // Model: remaining bits of the current frame (front = bit on the line) and one held byte.
    bit       m_cur[$];
    logic     m_hold_full = 1'b0;
    logic [7:0] m_hd = 8'd0;
    logic     m_hpe = 1'b0;
    logic     m_hpt = 1'b0;
    logic     m_acc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cur.delete();
            m_hold_full = 1'b0;
        end else begin
            m_acc = bus.data_valid && !m_hold_full;
            if (m_cur.size() > 0) void'(m_cur.pop_front());
            if (m_cur.size() == 0 && m_hold_full) begin
                m_cur.push_back(1'b0);
                for (int i = 0; i < 8; i++) m_cur.push_back(m_hd[i]);
                if (m_hpe) m_cur.push_back((^m_hd) ^ m_hpt);
                m_cur.push_back(1'b1);
                m_hold_full = 1'b0;
            end
            if (m_acc) begin
                m_hold_full = 1'b1;
                m_hd        = bus.p_data;
                m_hpe       = bus.par_en;
                m_hpt       = bus.par_typ;
            end
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_out", 32'(bus.tx_out), 32'((m_cur.size() > 0) ? m_cur[0] : 1'b1));
            check("start", 32'(bus.start), 32'(m_cur.size() > 0));
            check("busy", 32'(bus.busy), 32'((m_cur.size() > 0) || m_hold_full));
            check("ready", 32'(bus.ready), 32'(!m_hold_full));
        end
    end

    // Line capture of every cycle with start high, plus longest contiguous start run.
    bit cap[$];
    int run_len = 0;
    int max_run = 0;

    always @(negedge clk) begin
        if (rst && bus.start) begin
            cap.push_back(bus.tx_out);
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    task automatic clear_cap();
        cap.delete();
        max_run = 0;
    endtask

    task automatic check_cap(input string name, input logic [31:0] exp, input int n);
        logic [31:0] act;
        act = 32'd0;
        check({name, "_len"}, 32'(cap.size()), 32'(n));
        for (int i = 0; i < cap.size() && i < 32; i++) act = {act[30:0], cap[i]};
        check({name, "_bits"}, act, exp);
    endtask

    // Caller sits at a negedge; returns at the negedge after the acceptance edge.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        int n;
        n = 0;
        while (!bus.ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_timeout", 32'(bus.ready), 32'd1);
        bus.p_data     = d;
        bus.par_en     = pe;
        bus.par_typ    = pt;
        bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data_valid = 1'b0;
        bus.p_data     = ~d;
        bus.par_en     = ~pe;
        bus.par_typ    = ~pt;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    // Receiver-side decode of the captured frame.
    task automatic loopback(input logic [7:0] d, input logic pe, input logic pt);
        logic [7:0] rx;
        logic       par_error;
        logic       stop_error;
        clear_cap();
        send(d, pe, pt);
        wait_idle();
        rx         = 8'd0;
        par_error  = 1'b0;
        stop_error = 1'b1;
        check("lb_len", 32'(cap.size()), pe ? 32'd11 : 32'd10);
        if (cap.size() >= 10) begin
            for (int i = 0; i < 8; i++) rx[i] = cap[1 + i];
            if (pe) par_error = cap[9] ^ (^rx) ^ pt;
            stop_error = !cap[cap.size() - 1];
        end
        check("lb_data", 32'(rx), 32'(d));
        check("lb_par_error", 32'(par_error), 32'd0);
        check("lb_stop_error", 32'(stop_error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst            = 1'b0;
        bus.p_data     = 8'd0;
        bus.data_valid = 1'b0;
        bus.par_en     = 1'b0;
        bus.par_typ    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(bus.tx_out), 32'd1);
        check("rst_start", 32'(bus.start), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd1);
        chk_en = 1'b1;
        rst    = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5 even parity, with start-bit latency pinned.
        clear_cap();
        send(8'hA5, 1'b1, 1'b0);
        check("lat_hold_cycle_start", 32'(bus.start), 32'd0);
        check("lat_ready_low", 32'(bus.ready), 32'd0);
        @(negedge clk);
        check("lat_start_high", 32'(bus.start), 32'd1);
        check("lat_start_bit", 32'(bus.tx_out), 32'd0);
        wait_idle();
        check_cap("a5_even", 32'b01010010101, 11);
        check("a5_even_run", 32'(max_run), 32'd11);

        // 0xA5 odd parity.
        clear_cap();
        send(8'hA5, 1'b1, 1'b1);
        wait_idle();
        check_cap("a5_odd", 32'b01010010111, 11);

        // 0x3C without parity, then idle.
        clear_cap();
        send(8'h3C, 1'b0, 1'b0);
        wait_idle();
        check_cap("3c_nopar", 32'b0001111001, 10);
        check("3c_idle_tx", 32'(bus.tx_out), 32'd1);
        check("3c_idle_start", 32'(bus.start), 32'd0);

        // Back-to-back 0x01 then 0x80; junk requests while ready is low must be ignored.
        clear_cap();
        send(8'h01, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        send(8'h80, 1'b0, 1'b0);
        check("b2b_ready_low", 32'(bus.ready), 32'd0);
        bus.p_data     = 8'hEE;
        bus.data_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.data_valid = 1'b0;
        wait_idle();
        check_cap("b2b", 32'b01000000010000000011, 20);
        check("b2b_contig", 32'(max_run), 32'd20);

        // Reset during data bit 4 of 0xFF with a byte held.
        send(8'hFF, 1'b0, 1'b0);
        n = 0;
        while (!bus.start && n < 20) begin
            @(negedge clk);
            n++;
        end
        send(8'h12, 1'b0, 1'b0);
        check("rstmid_held", 32'(bus.ready), 32'd0);
        n = 0;
        while (m_cur.size() != 5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_in_bit4", 32'(m_cur.size()), 32'd5);
        #2 rst = 1'b0;
        #1;
        check("rstmid_tx", 32'(bus.tx_out), 32'd1);
        check("rstmid_busy", 32'(bus.busy), 32'd0);
        check("rstmid_ready", 32'(bus.ready), 32'd1);
        check("rstmid_start", 32'(bus.start), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        clear_cap();
        repeat (20) @(negedge clk);
        check("rstmid_no_bits", 32'(cap.size()), 32'd0);

        // Loopback decode.
        loopback(8'h00, 1'b1, 1'b0);
        loopback(8'hFF, 1'b1, 1'b1);
        loopback(8'hA5, 1'b0, 1'b0);
        loopback(8'h5A, 1'b1, 1'b1);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
